// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high time of a signal, in clock cycles,
// from the single-cycle rise/fall pulses of an upstream edge detector.
// Each finished measurement lands in a one-entry output register.
//
// Output handshake (valid/ready): a result transfers on any rising edge
// where valid_o and ready_i are both high. While valid_o is high and
// ready_i is low, valid_o/width_o/ovf_o hold steady. A result finishing
// while the register is full and not being drained is dropped, and
// drop_o pulses for one cycle.
module pulse_width_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rise_i,
    input  logic             fall_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] width_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             drop_o,
    output logic             state_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic             start;
    logic             finish;
    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    // The register can take a new result if it is empty or being drained now.
    assign accept  = !valid_o || ready_i;
    assign consume = valid_o && ready_i;
    assign busy_o  = (state_q == MEASURE);
    assign state_o = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A coincident rise/fall acts as rise in IDLE and as
    // fall in MEASURE, because each state only looks at one of the pulses.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_i) begin
                    start   = 1'b1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (fall_i) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating high-time counter; the fall cycle itself is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (start) begin
            cnt <= CNT_W'(1);
            // Only reachable when the counter is a single bit wide.
            sat <= (CNT_MAX == CNT_W'(1));
        end else if (busy_o && !fall_i && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) begin
                sat <= 1'b1;
            end
        end
    end

    // One-entry result register with drop reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_o <= 1'b0;
            width_o <= '0;
            ovf_o   <= 1'b0;
            drop_o  <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            if (finish) begin
                if (accept) begin
                    valid_o <= 1'b1;
                    width_o <= cnt;
                    ovf_o   <= sat;
                end else begin
                    drop_o <= 1'b1;
                end
            end else if (consume) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed and random stimulus for pulse_width_meter
// against a cycle-numbered reference model (width = fall cycle - rise cycle).
module tb_pulse_width_meter;

    localparam int CNT_W = 4;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             rise_i;
    logic             fall_i;
    logic             ready_i;
    logic             valid_o;
    logic [CNT_W-1:0] width_o;
    logic             ovf_o;
    logic             busy_o;
    logic             drop_o;
    logic             state_o;

    int errors = 0;
    int checks = 0;

    // reference model state
    int               cyc;
    int               rise_cyc;
    logic             m_busy;
    logic             m_valid;
    logic [CNT_W-1:0] m_width;
    logic             m_ovf;
    logic             m_drop;
    logic [CNT_W:0]   exp_q[$];

    pulse_width_meter #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .rise_i  (rise_i),
        .fall_i  (fall_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .width_o (width_o),
        .ovf_o   (ovf_o),
        .busy_o  (busy_o),
        .drop_o  (drop_o),
        .state_o (state_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_width = '0;
        m_ovf   = 1'b0;
        m_drop  = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, valid_o, m_valid);
        chk({tag, "_width"}, width_o, m_width);
        chk({tag, "_ovf"},   ovf_o,   m_ovf);
        chk({tag, "_busy"},  busy_o,  m_busy);
        chk({tag, "_state"}, state_o, m_busy);
        chk({tag, "_drop"},  drop_o,  m_drop);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_width"}, width_o, 0);
        chk({tag, "_ovf"},   ovf_o,   0);
        chk({tag, "_busy"},  busy_o,  0);
        chk({tag, "_drop"},  drop_o,  0);
    endtask

    // driver: apply one cycle of inputs, advance model, compare after the edge
    task automatic cycle(input logic r, input logic f, input logic rdy);
        logic           load;
        int             n;
        logic [CNT_W:0] exp;
        rise_i  = r;
        fall_i  = f;
        ready_i = rdy;
        // scoreboard: a transfer happens on this edge
        if (valid_o && rdy) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                chk("sb_data", {ovf_o, width_o}, exp);
            end
        end
        load   = 1'b0;
        m_drop = 1'b0;
        if (!m_busy) begin
            if (r) begin
                m_busy   = 1'b1;
                rise_cyc = cyc;
            end
        end else if (f) begin
            n      = cyc - rise_cyc;
            m_busy = 1'b0;
            if (!m_valid || rdy) begin
                load    = 1'b1;
                m_valid = 1'b1;
                m_width = (n >= MAX) ? CNT_W'(MAX) : CNT_W'(n);
                m_ovf   = (n >= MAX);
                exp_q.push_back({m_ovf, m_width});
            end else begin
                m_drop = 1'b1;
            end
        end
        if (!load && m_valid && rdy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs("cyc");
    endtask

    task automatic pulse(input int n, input logic rdy);
        cycle(1'b1, 1'b0, rdy);
        for (int i = 1; i < n; i++) cycle(1'b0, 1'b0, rdy);
    endtask

    initial begin
        cyc = 0;
        rise_cyc = 0;
        reset = 1'b0;
        rise_i = 1'b0;
        fall_i = 1'b0;
        ready_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // basic: width 5 with ready held high, visible for one cycle
        pulse(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("basic_width", width_o, 5);
        chk("basic_valid", valid_o, 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("basic_valid_clr", valid_o, 0);

        // minimum width then back-to-back width 3
        pulse(1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("min_width", width_o, 1);
        pulse(3, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("b2b_width", width_o, 3);
        chk("b2b_drop", drop_o, 0);
        cycle(1'b0, 1'b0, 1'b1);

        // saturation: 20-cycle high time, then a 3-cycle pulse
        pulse(20, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("sat_width", width_o, 15);
        chk("sat_ovf", ovf_o, 1);
        pulse(3, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("after_sat_width", width_o, 3);
        chk("after_sat_ovf", ovf_o, 0);
        cycle(1'b0, 1'b0, 1'b1);

        // backpressure: width 2 held, width 7 dropped
        pulse(2, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        pulse(7, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("bp_drop", drop_o, 1);
        chk("bp_width", width_o, 2);
        chk("bp_valid", valid_o, 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("bp_drop_once", drop_o, 0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("bp_drain", valid_o, 0);

        // same-cycle consume and load: width 6 held, width 4 replaces it
        pulse(6, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        pulse(4, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("swap_width", width_o, 4);
        chk("swap_valid", valid_o, 1);
        chk("swap_drop", drop_o, 0);

        // reset mid-measurement with a held result
        pulse(3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        for (int i = 0; i < 3; i++) begin
            fall_i = (i == 1);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        reset = 1'b1;
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_drop", drop_o, 0);

        // random traffic, including coincident rise/fall and stalls
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
